mdu_unit: RTL

Multi-cycle multiply/divide unit for the MIPS datapath, the parametrised successor to the single-cycle combinational ALU. It sits beside the ALU in the execute stage and owns the HI/LO architectural registers. It executes MULT, MULTU, DIV, DIVU over a configurable number of cycles and MTHI/MTLO in one edge. It reports `busy` so the hazard unit can stall MFHI/MFLO and any new MDU instruction.

---
 rtl/mdu_if.sv | 24 ++
 rtl/mdu_unit.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/mdu_if.sv
// Handshake and result bus between the execute stage and the multiply/divide unit.
interface mdu_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [2:0]       op;
    logic [WIDTH-1:0] S1;
    logic [WIDTH-1:0] S2;
    logic             flush;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] HI;
    logic [WIDTH-1:0] LO;

    modport master (
        output start, op, S1, S2, flush,
        input  busy, done, HI, LO
    );

    modport slave (
        input  start, op, S1, S2, flush,
        output busy, done, HI, LO
    );
endinterface

// File: rtl/mdu_unit.sv
// Multi-cycle multiply/divide unit owning the HI/LO registers.
// The result is formed from the operands at the accept edge and held in
// hi_nx/lo_nx; the down-counter only models the architectural latency.
module mdu_unit #(
    parameter int WIDTH    = 32,
    parameter int MULT_LAT = 5,
    parameter int DIV_LAT  = 10
) (
    input logic   clk,
    input logic   rst_n,
    mdu_if.slave  bus
);
    localparam int MAXLAT = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
    localparam int CW     = $clog2(MAXLAT + 1);
    localparam logic [WIDTH-1:0] SMIN = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);

    typedef enum logic {IDLE, RUN} state_t;
    typedef enum logic [2:0] {
        OP_MULT  = 3'd0,
        OP_MULTU = 3'd1,
        OP_DIV   = 3'd2,
        OP_DIVU  = 3'd3,
        OP_MTHI  = 3'd4,
        OP_MTLO  = 3'd5,
        OP_NOP6  = 3'd6,
        OP_NOP7  = 3'd7
    } op_t;

    state_t           state, state_n;
    logic [CW-1:0]    cnt, cnt_n;
    logic [WIDTH-1:0] hi_nx, hi_nx_n, lo_nx, lo_nx_n;
    logic             commit, commit_n;
    logic             busy_q, busy_n;
    logic             done_q, done_n;
    logic [WIDTH-1:0] hi_q, hi_n, lo_q, lo_n;
    op_t              op;

    logic signed [2*WIDTH-1:0] s1_sx, s2_sx;
    logic [2*WIDTH-1:0]        prod_s, prod_u;
    logic                      div_zero, div_ovf;
    logic [WIDTH-1:0]          dvs_s, dvs_u;
    logic [WIDTH-1:0]          quo_s, rem_s, quo_u, rem_u;

    assign op = op_t'(bus.op);

    // Product and quotient/remainder of the presented operands.
    // Zero and overflowing divisors are replaced by 1 so the divider never
    // sees them; their architectural results are selected explicitly below.
    always_comb begin
        s1_sx    = signed'({{WIDTH{bus.S1[WIDTH-1]}}, bus.S1});
        s2_sx    = signed'({{WIDTH{bus.S2[WIDTH-1]}}, bus.S2});
        prod_s   = unsigned'(s1_sx * s2_sx);
        prod_u   = {{WIDTH{1'b0}}, bus.S1} * {{WIDTH{1'b0}}, bus.S2};
        div_zero = (bus.S2 == '0);
        div_ovf  = (bus.S1 == SMIN) && (bus.S2 == '1);
        dvs_s    = (div_zero || div_ovf) ? ONE : bus.S2;
        dvs_u    = div_zero ? ONE : bus.S2;
        quo_s    = unsigned'($signed(bus.S1) / $signed(dvs_s));
        rem_s    = unsigned'($signed(bus.S1) % $signed(dvs_s));
        quo_u    = bus.S1 / dvs_u;
        rem_u    = bus.S1 % dvs_u;
        if (div_ovf) begin
            quo_s = SMIN;
            rem_s = '0;
        end
    end

    // State register, countdown and HI/LO storage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            cnt    <= '0;
            hi_nx  <= '0;
            lo_nx  <= '0;
            commit <= 1'b0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            hi_q   <= '0;
            lo_q   <= '0;
        end else begin
            state  <= state_n;
            cnt    <= cnt_n;
            hi_nx  <= hi_nx_n;
            lo_nx  <= lo_nx_n;
            commit <= commit_n;
            busy_q <= busy_n;
            done_q <= done_n;
            hi_q   <= hi_n;
            lo_q   <= lo_n;
        end
    end

    // Accept, countdown, flush and commit decisions.
    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        hi_nx_n  = hi_nx;
        lo_nx_n  = lo_nx;
        commit_n = commit;
        done_n   = 1'b0;
        hi_n     = hi_q;
        lo_n     = lo_q;
        case (state)
            IDLE: begin
                if (bus.start && !bus.flush) begin
                    case (op)
                        OP_MULT: begin
                            state_n  = RUN;
                            cnt_n    = CW'(MULT_LAT);
                            hi_nx_n  = prod_s[2*WIDTH-1:WIDTH];
                            lo_nx_n  = prod_s[WIDTH-1:0];
                            commit_n = 1'b1;
                        end
                        OP_MULTU: begin
                            state_n  = RUN;
                            cnt_n    = CW'(MULT_LAT);
                            hi_nx_n  = prod_u[2*WIDTH-1:WIDTH];
                            lo_nx_n  = prod_u[WIDTH-1:0];
                            commit_n = 1'b1;
                        end
                        OP_DIV: begin
                            state_n  = RUN;
                            cnt_n    = CW'(DIV_LAT);
                            hi_nx_n  = rem_s;
                            lo_nx_n  = quo_s;
                            commit_n = !div_zero;
                        end
                        OP_DIVU: begin
                            state_n  = RUN;
                            cnt_n    = CW'(DIV_LAT);
                            hi_nx_n  = rem_u;
                            lo_nx_n  = quo_u;
                            commit_n = !div_zero;
                        end
                        OP_MTHI: hi_n = bus.S1;
                        OP_MTLO: lo_n = bus.S1;
                        default: ;
                    endcase
                end
            end
            RUN: begin
                if (bus.flush) begin
                    state_n = IDLE;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt - CW'(1);
                    if (cnt == CW'(1)) begin
                        state_n = IDLE;
                        done_n  = 1'b1;
                        if (commit) begin
                            hi_n = hi_nx;
                            lo_n = lo_nx;
                        end
                    end
                end
            end
            default: begin
                state_n = IDLE;
                cnt_n   = '0;
            end
        endcase
        busy_n = (cnt_n != '0);
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.HI   = hi_q;
    assign bus.LO   = lo_q;
endmodule
